// File: rtl/lsu_stage_if.sv
// Memory port of the load/store stage: request/grant handshake plus an
// independent load-response channel. The LSU is the master, memory the slave.
interface lsu_stage_if #(
  parameter int XLEN = 32
);
  logic              req;
  logic              we;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store memory stage. Issues byte-enabled requests over a
// request/grant/response port, stalls upstream while a transaction is
// outstanding, and registers extended load data / fault status for writeback.
module lsu_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_noop,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_res,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_mem_rd,
  output logic            out_fault,
  lsu_stage_if.master     mem
);

  localparam int BW   = XLEN / 8;
  localparam int OFFW = $clog2(BW);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t state, state_nx;

  logic            is_load, is_store, mem_op;
  logic [1:0]      size;
  logic [OFFW-1:0] off, align_mask;
  logic [BW-1:0]   size_mask, be_c;
  logic [XLEN-1:0] addr_c, wdata_c;
  logic            illegal, misaligned, fault;

  logic [XLEN-1:0] lat_addr, lat_wdata;
  logic [BW-1:0]   lat_be;
  logic            lat_we;
  logic [2:0]      lat_funct3;
  logic [OFFW-1:0] lat_off;
  logic [CW-1:0]   cnt;
  logic            timeout_hit;

  logic            req_c, we_c, latch, complete, fault_done, load_done;
  logic [BW-1:0]   be_o;
  logic [XLEN-1:0] addr_o, wdata_o;

  logic [XLEN-1:0] sh, ext_mask, ext;
  logic [6:0]      sw;
  logic            sign;

  // Decode the incoming instruction into lane enables, aligned address,
  // replicated store data and fault status.
  always_comb begin
    is_load  = (in_opcode == 7'b0000011);
    is_store = (in_opcode == 7'b0100011);
    mem_op   = in_valid & ~in_noop & (is_load | is_store);
    size     = in_funct3[1:0];
    off      = in_res[OFFW-1:0];
    addr_c   = {in_res[XLEN-1:OFFW], {OFFW{1'b0}}};

    size_mask  = '1;
    align_mask = '1;
    wdata_c    = in_rs2_data;
    case (size)
      2'd0: begin
        size_mask  = BW'(1);
        align_mask = '0;
        wdata_c    = {BW{in_rs2_data[7:0]}};
      end
      2'd1: begin
        size_mask  = BW'(3);
        align_mask = OFFW'(1);
        wdata_c    = {(BW/2){in_rs2_data[15:0]}};
      end
      2'd2: begin
        size_mask  = BW'(15);
        align_mask = OFFW'(3);
        wdata_c    = {(BW/4){in_rs2_data[31:0]}};
      end
      default: begin
        size_mask  = '1;
        align_mask = '1;
        wdata_c    = in_rs2_data;
      end
    endcase
    be_c = size_mask << off;

    illegal    = ((XLEN == 32) && (in_funct3 == 3'd3 || in_funct3 == 3'd6)) ||
                 (is_load && in_funct3 == 3'd7) ||
                 (is_store && in_funct3[2]);
    misaligned = |(off & align_mask);
    fault      = illegal | misaligned;
  end

  assign timeout_hit = (TIMEOUT > 0) && (state != IDLE) && (cnt == CW'(TIMEOUT - 1));

  // Next-state and memory-port drive. A grant or response arriving in the
  // timeout cycle wins over the timeout.
  always_comb begin
    state_nx   = state;
    req_c      = 1'b0;
    we_c       = 1'b0;
    be_o       = '0;
    addr_o     = '0;
    wdata_o    = '0;
    latch      = 1'b0;
    complete   = 1'b0;
    fault_done = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (fault) begin
            complete   = 1'b1;
            fault_done = 1'b1;
          end else begin
            req_c   = 1'b1;
            we_c    = is_store;
            be_o    = be_c;
            addr_o  = addr_c;
            wdata_o = wdata_c;
            latch   = 1'b1;
            if (mem.gnt) begin
              if (is_store) complete = 1'b1;
              else          state_nx = RSP;
            end else begin
              state_nx = REQ;
            end
          end
        end
      end
      REQ: begin
        req_c   = 1'b1;
        we_c    = lat_we;
        be_o    = lat_be;
        addr_o  = lat_addr;
        wdata_o = lat_wdata;
        if (mem.gnt) begin
          if (lat_we) begin
            complete = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = RSP;
          end
        end else if (timeout_hit) begin
          complete   = 1'b1;
          fault_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      RSP: begin
        if (mem.rvalid) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_nx  = IDLE;
        end else if (timeout_hit) begin
          complete   = 1'b1;
          fault_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request and stall are masked by reset so they drop the instant it asserts.
  assign mem.req   = req_c & ~rst;
  assign mem.we    = we_c;
  assign mem.be    = be_o;
  assign mem.addr  = addr_o;
  assign mem.wdata = wdata_o;
  assign stall     = mem_op & ~complete & ~rst;

  // Align and extend the response word using the latched size/offset.
  always_comb begin
    sh       = mem.rdata >> {lat_off, 3'b000};
    sw       = 7'd8 << lat_funct3[1:0];
    ext_mask = ~({XLEN{1'b1}} << sw);
    sign     = |(sh & ext_mask & ~(ext_mask >> 1));
    ext      = (lat_funct3[2] | ~sign) ? (sh & ext_mask) : (sh | ~ext_mask);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Capture the request on issue so REQ/RSP do not depend on upstream inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_we     <= 1'b0;
      lat_funct3 <= '0;
      lat_off    <= '0;
    end else if (latch) begin
      lat_addr   <= addr_c;
      lat_wdata  <= wdata_c;
      lat_be     <= be_c;
      lat_we     <= is_store;
      lat_funct3 <= in_funct3;
      lat_off    <= off;
    end
  end

  // Per-state cycle counter for the timeout; cleared whenever a state is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (state_nx != state) cnt <= '0;
    else if (state != IDLE)     cnt <= cnt + CW'(1);
  end

  // Writeback-facing registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_fault  <= 1'b0;
      out_mem_rd <= '0;
    end else begin
      out_valid <= in_valid & ~stall;
      out_fault <= fault_done;
      if (load_done) out_mem_rd <= ext;
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: a 32-bit instance (TIMEOUT=4) and a 64-bit instance
// (timeout disabled) exercised one at a time, with expectations computed from
// the access rules by plain arithmetic.
module tb_lsu_stage;

  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] ALU_OP = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        in_valid, in_noop;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [63:0] in_rs2, in_res, rdata;
  logic        gnt, rvalid;

  logic        stall32, ov32, of32;
  logic [31:0] rd32;
  logic        stall64, ov64, of64;
  logic [63:0] rd64;

  logic        o_req, o_we, o_stall, o_valid, o_fault;
  logic [7:0]  o_be;
  logic [63:0] o_addr, o_wdata, o_rd;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [63:0] exp_rd [2];

  always #5 clk = ~clk;

  lsu_stage_if #(.XLEN(32)) m32 ();
  lsu_stage_if #(.XLEN(64)) m64 ();

  assign m32.gnt    = gnt & ~sel;
  assign m32.rvalid = rvalid & ~sel;
  assign m32.rdata  = rdata[31:0];
  assign m64.gnt    = gnt & sel;
  assign m64.rvalid = rvalid & sel;
  assign m64.rdata  = rdata;

  lsu_stage #(.XLEN(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_noop(in_noop), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_rs2_data(in_rs2[31:0]), .in_res(in_res[31:0]),
    .stall(stall32), .out_valid(ov32), .out_mem_rd(rd32), .out_fault(of32),
    .mem(m32)
  );

  lsu_stage #(.XLEN(64), .TIMEOUT(0)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_noop(in_noop), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_rs2_data(in_rs2), .in_res(in_res),
    .stall(stall64), .out_valid(ov64), .out_mem_rd(rd64), .out_fault(of64),
    .mem(m64)
  );

  assign o_req   = sel ? m64.req   : m32.req;
  assign o_we    = sel ? m64.we    : m32.we;
  assign o_be    = sel ? m64.be    : {4'b0, m32.be};
  assign o_addr  = sel ? m64.addr  : {32'b0, m32.addr};
  assign o_wdata = sel ? m64.wdata : {32'b0, m32.wdata};
  assign o_stall = sel ? stall64   : stall32;
  assign o_valid = sel ? ov64      : ov32;
  assign o_fault = sel ? of64      : of32;
  assign o_rd    = sel ? rd64      : {32'b0, rd32};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected load result: shift the word down by the offset, keep the access
  // size, sign- or zero-extend, then fit to the datapath width.
  function automatic logic [63:0] load_val(input int xl, input logic [2:0] f3,
                                           input int off, input logic [63:0] rd);
    int nb;
    logic [63:0] v, m;
    nb = 1 << f3[1:0];
    v  = ((xl == 32) ? (rd & 64'hFFFF_FFFF) : rd) >> (8 * off);
    m  = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v  = v & m;
    if (!f3[2] && v[8*nb-1]) v = v | ~m;
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // One instruction on DUT s (0: 32-bit, 1: 64-bit). Entered and left at a
  // falling edge. g = cycles until grant, r = cycles from grant to response
  // (negative: never).
  task automatic op(input bit s, input logic [6:0] opc, input logic [2:0] f3,
                    input logic [63:0] a, input logic [63:0] rs2, input logic [63:0] rd,
                    input int g, input int r, input bit noop, input bit valid);
    int xl, t, nb, off, n;
    bit memop, ld, flt, legal, tmo;
    logic [63:0] e_be, e_addr, e_wd;
    xl  = s ? 64 : 32;
    t   = s ? 0 : 4;
    ld  = (opc == LD_OP);
    memop = valid && !noop && (ld || opc == ST_OP);
    nb  = 1 << f3[1:0];
    off = int'(a[2:0]) % (xl / 8);
    flt = memop && (((xl == 32) && (f3 == 3'd3 || f3 == 3'd6)) || (ld && f3 == 3'd7) ||
                    (!ld && f3 >= 3'd4) || (off % nb != 0));
    legal  = memop && !flt;
    e_be   = ((64'd1 << nb) - 64'd1) << off;
    e_addr = (xl == 32) ? (a & 64'hFFFF_FFFC) : (a & ~64'h7);
    e_wd   = '0;
    for (int i = 0; i < xl / 8; i++) e_wd[8*i +: 8] = rs2[8*(i % nb) +: 8];

    tmo = 1'b0;
    n   = 0;
    if (legal) begin
      if (t > 0 && g > t) begin
        n = t; tmo = 1'b1;
      end else if (!ld) begin
        n = g;
      end else if (t > 0 && (r < 0 || r > t)) begin
        n = g + t; tmo = 1'b1;
      end else begin
        n = g + r;
      end
    end

    sel = s; in_valid = valid; in_noop = noop; in_opcode = opc; in_funct3 = f3;
    in_rs2 = rs2; in_res = a; rdata = rd;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) @(negedge clk);
      gnt    = legal && (c == g);
      rvalid = legal && ld && (r >= 0) && (c == g + r);
      #1;
      if (c > 0) chk("out_valid_while_stalled", o_valid, 0);
      chk("stall", o_stall, (c < n));
      chk("mem_req", o_req, legal && (c <= g));
      if (legal && c <= g) begin
        chk("mem_we", o_we, !ld);
        chk("mem_be", o_be, e_be);
        chk("mem_addr", o_addr, e_addr);
        chk("mem_wdata", o_wdata, e_wd);
      end
    end
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b0;
    if (legal && ld && !tmo) exp_rd[s] = load_val(xl, f3, off, rd);
    chk("out_valid", o_valid, valid);
    chk("out_fault", o_fault, flt || tmo);
    chk("out_mem_rd", o_rd, exp_rd[s]);
    in_valid = 1'b0; in_noop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [63:0] a;
    int          k, nb;

    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_noop = 1'b0; in_opcode = '0;
    in_funct3 = '0; in_rs2 = '0; in_res = '0; rdata = '0; gnt = 1'b0; rvalid = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;

    #1;
    chk("rst32_valid", o_valid, 0);
    chk("rst32_fault", o_fault, 0);
    chk("rst32_rd", o_rd, 0);
    chk("rst32_req", o_req, 0);
    sel = 1'b1;
    #1;
    chk("rst64_valid", o_valid, 0);
    chk("rst64_rd", o_rd, 0);
    @(negedge clk);
    rst = 1'b0;

    // LB from the top byte lane, response two cycles after grant.
    op(0, LD_OP, 3'b000, 64'h1003, 64'h0, 64'h80AA_BBCC, 0, 2, 0, 1);
    chk("lb_result", o_rd, 64'h0000_0000_FFFF_FF80);
    // SH with grant delayed three cycles.
    op(0, ST_OP, 3'b001, 64'h1002, 64'h1234_ABCD, 64'h0, 3, 0, 0, 1);
    // Misaligned LW and LD on the 32-bit datapath both fault.
    op(0, LD_OP, 3'b010, 64'h1001, 64'h0, 64'h0, 0, 1, 0, 1);
    op(0, LD_OP, 3'b011, 64'h1000, 64'h0, 64'h0, 0, 1, 0, 1);
    chk("ld32_fault", o_fault, 1);
    // Non-memory op, bubble and an empty slot.
    op(0, ALU_OP, 3'b010, 64'h1000, 64'h0, 64'h0, 0, 1, 0, 1);
    op(0, LD_OP, 3'b010, 64'h1000, 64'h0, 64'h0, 0, 1, 1, 1);
    op(0, LD_OP, 3'b010, 64'h1000, 64'h0, 64'h0, 0, 1, 0, 0);
    // Back-to-back stores granted immediately.
    op(0, ST_OP, 3'b000, 64'h2001, 64'h0000_00A5, 64'h0, 0, 0, 0, 1);
    op(0, ST_OP, 3'b010, 64'h2004, 64'hDEAD_BEEF, 64'h0, 0, 0, 0, 1);

    // 64-bit: LWU from the upper word, SD full lanes.
    op(1, LD_OP, 3'b110, 64'h8000_0000_0000_1004, 64'h0, 64'hF000_0001_0000_0000, 1, 1, 0, 1);
    chk("lwu_result", o_rd, 64'h0000_0000_F000_0001);
    op(1, ST_OP, 3'b011, 64'h1008, 64'h0102_0304_0506_0708, 64'h0, 0, 0, 0, 1);
    op(1, LD_OP, 3'b011, 64'h10, 64'h0, 64'h8765_4321_0FED_CBA9, 2, 3, 0, 1);

    // Response never arrives: timeout fault, then a late response is ignored.
    op(0, LD_OP, 3'b000, 64'h3000, 64'h0, 64'h55, 0, -1, 0, 1);
    chk("timeout_fault", o_fault, 1);
    sel = 1'b0; rvalid = 1'b1; rdata = 64'h0000_1234;
    #1;
    chk("late_rvalid_stall", o_stall, 0);
    chk("late_rvalid_req", o_req, 0);
    @(negedge clk);
    rvalid = 1'b0;
    chk("late_rvalid_valid", o_valid, 0);
    chk("late_rvalid_fault", o_fault, 0);
    chk("late_rvalid_rd", o_rd, exp_rd[0]);
    op(0, LD_OP, 3'b100, 64'h3002, 64'h0, 64'h00C3_0000, 0, 1, 0, 1);

    // Reset while a 64-bit load waits in RSP.
    sel = 1'b1; in_valid = 1'b1; in_noop = 1'b0; in_opcode = LD_OP; in_funct3 = 3'b011;
    in_res = 64'h2000; gnt = 1'b1;
    #1;
    chk("pre_rst_req", o_req, 1);
    @(negedge clk);
    gnt = 1'b0;
    #1;
    chk("rsp_req", o_req, 0);
    chk("rsp_stall", o_stall, 1);
    #1;
    rst = 1'b1;
    #1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    chk("async_rst_req", o_req, 0);
    chk("async_rst_stall", o_stall, 0);
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_fault", o_fault, 0);
    chk("async_rst_rd", o_rd, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    op(1, LD_OP, 3'b011, 64'h2000, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 2, 0, 1);

    // Randomized mix on both datapaths.
    for (int it = 0; it < 80; it++) begin
      k   = $urandom_range(0, 9);
      f3  = 3'($urandom_range(0, 7));
      nb  = 1 << f3[1:0];
      a   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
      opc = (k == 0) ? ALU_OP : (($urandom_range(0, 1) != 0) ? LD_OP : ST_OP);
      op(1'($urandom_range(0, 1)), opc, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
         $urandom_range(0, 5), $urandom_range(1, 6), (k == 1), (k != 9));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
# lsu_stage

Parametrised load/store memory stage for the RISC-V core; successor to the single-cycle data-memory access stage. Issues byte-enabled requests over a request/grant/response memory port with arbitrary latency, stalls upstream while a transaction is outstanding, and returns aligned, sign/zero-extended load data. Also flags misaligned, illegal-width and timed-out accesses. Sits between execute and writeback.

## Interface
- XLEN, 32, datapath/address width; 32 or 64 only.
- TIMEOUT, 0, max cycles spent in REQ or RSP before fault; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  instruction present this cycle.
- in_noop  in  1  bubble; treated as not a memory op.
- in_opcode  in  7  0000011 load, 0100011 store; anything else is not a memory op.
- in_funct3  in  3  access size/sign.
- in_rs2_data  in  XLEN  store data.
- in_res  in  XLEN  effective byte address.
- stall  out  1  upstream must hold all in_* stable while high.
- out_valid  out  1  result/completion registered for writeback.
- out_mem_rd  out  XLEN  extended load data.
- out_fault  out  1  access not performed (misaligned, illegal, timeout).
- mem_req  out  1  request valid.
- mem_we  out  1  1 store, 0 load.
- mem_be  out  XLEN/8  byte enables.
- mem_addr  out  XLEN  in_res with low log2(XLEN/8) bits cleared.
- mem_wdata  out  XLEN  store data replicated across lanes.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load response valid; only ever 1+ cycles after gnt.
- mem_rdata  in  XLEN  full aligned word.

## Operation
- Size from funct3[1:0]: 0 byte, 1 half, 2 word, 3 double. Loads: funct3[2] means zero-extend.
- Illegal accesses raise a fault:
  - funct3 3 or 6 when XLEN=32.
  - Load funct3 7.
  - Store funct3 ≥4.
- Misaligned means address not a multiple of the size; also a fault.
- Byte offset `off` = in_res[log2(XLEN/8)-1:0].
- mem_be = size mask (1, 3, 0xF, 0xFF) << off.
- Store data: the low size bytes of rs2 are replicated to every lane.
- Load data: mem_rdata >> (8*off), truncated to size, then sign- or zero-extended to XLEN.
- Mem op = in_valid & !in_noop & opcode load/store.
- Faulting mem ops never assert mem_req.
- FSM states IDLE, REQ, RSP:
  - IDLE, legal mem op: mem_req = 1, driven combinationally from in_*.
    - gnt & store: complete; stay IDLE.
    - gnt & load: go RSP.
    - !gnt: latch address/we/be/wdata/funct3/off, go REQ.
  - REQ: mem_req = 1 from latched registers, stable until gnt.
    - gnt & store: complete, go IDLE.
    - gnt & load: go RSP.
  - RSP: mem_req = 0. On mem_rvalid, capture extended data, go IDLE.
- mem_rvalid outside RSP is ignored.
- Timeout (TIMEOUT>0): a cycle counter, cleared on every state entry, counts cycles spent in REQ/RSP.
  - When it reaches TIMEOUT, the access is dropped, a fault completion is issued and the FSM goes IDLE.
  - A late rvalid after such an abort is ignored.
- stall = mem op & not completing this cycle.
  - Stall falls in the cycle of gnt (store) or rvalid (load).
- Registered outputs, updated on each clk edge:
  - out_valid ← in_valid & !stall.
  - out_fault ← completion of a faulting/timed-out op.
  - out_mem_rd ← extended data, only on load completion; holds otherwise.
- Non-mem instructions and faults: no stall, out_valid the next cycle.

## Timing
- Reset values: state IDLE, out_valid 0, out_fault 0, out_mem_rd 0, counter 0, latched regs 0.
- mem_req drops immediately on rst assertion (async); any in-flight transaction is abandoned.
- Store, gnt in the request cycle: 0 stall cycles; out_valid next edge.
- Load, gnt in cycle 0, rvalid in cycle N≥1:
  - stall high cycles 0..N-1, low in N.
  - out_valid and out_mem_rd valid in cycle N+1.
- Back-to-back ops: a new request may issue in the cycle right after completion.
- A load completing with in_valid low still produces no out_valid, because in_valid gates it; upstream holds in_valid while stalled.
- Timeout fires on the TIMEOUT-th cycle spent in REQ or RSP.

## Test plan
- XLEN=32, LB at 0x1003, mem_rdata 0x80AA_BBCC, gnt cycle 0, rvalid cycle 2 -> mem_be 0x8, stall high 2 cycles, out_mem_rd 0xFFFF_FF80 in cycle 3.
- SH at 0x1002 with rs2 0x1234_ABCD, gnt delayed 3 cycles -> mem_be 0xC, mem_wdata 0xABCD_ABCD held stable, stall 3 cycles, then out_valid.
- LW at 0x1001 -> no mem_req, out_fault=1 and out_valid=1 next cycle; LD with XLEN=32 also faults.
- XLEN=64, LWU at 0x...04, mem_rdata 0xF000_0001_0000_0000 -> out_mem_rd 0x0000_0000_F000_0001; SD -> mem_be 0xFF.
- TIMEOUT=4, load granted, rvalid never arrives -> out_fault after 4 RSP cycles; a later rvalid is ignored.
- rst asserted mid-RSP -> mem_req 0, stall 0, outputs at reset values immediately; the next load completes normally.
